// File: rtl/instruction_loader.sv
// Instruction-memory writer: assembles a big-endian byte stream into 32-bit words and holds the CPU until loaded.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before the image is accepted.
module instruction_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            byteIn,
  input  logic                  byteValid,
  output logic                  byteReady,
  output logic                  memWrite,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [31:0]           memData,
  output logic                  cpuHold,
  output logic                  done,
  output logic                  error
);

  localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_WIDTH);

  typedef enum logic [2:0] {
    COUNT_HI,
    COUNT_LO,
    DATA,
    WRITE,
`ifdef LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE,
    ERROR
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t AFTER_LAST = CHECK;
`else
  localparam state_t AFTER_LAST = DONE;
`endif

  state_t                stateReg, stateNext;
  logic                  armedReg;
  logic [15:0]           countReg, countNext;
  logic [ADDR_WIDTH:0]   writtenReg, writtenNext;
  logic [ADDR_WIDTH-1:0] addrReg, addrNext;
  logic [31:0]           wordReg, wordNext;
  logic [1:0]            byteIdxReg, byteIdxNext;
  logic                  transfer;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            xorReg, xorNext;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg   <= COUNT_HI;
      armedReg   <= 1'b0;
      countReg   <= '0;
      writtenReg <= '0;
      addrReg    <= '0;
      wordReg    <= '0;
      byteIdxReg <= '0;
`ifdef LOADER_CHECKSUM_EN
      xorReg     <= '0;
`endif
    end else begin
      stateReg   <= stateNext;
      armedReg   <= 1'b1;
      countReg   <= countNext;
      writtenReg <= writtenNext;
      addrReg    <= addrNext;
      wordReg    <= wordNext;
      byteIdxReg <= byteIdxNext;
`ifdef LOADER_CHECKSUM_EN
      xorReg     <= xorNext;
`endif
    end
  end

  always_comb begin
    stateNext   = stateReg;
    countNext   = countReg;
    writtenNext = writtenReg;
    addrNext    = addrReg;
    wordNext    = wordReg;
    byteIdxNext = byteIdxReg;
    byteReady   = 1'b0;
    memWrite    = 1'b0;

    // Byte acceptance waits one clock after reset release so the source sees a clean start.
    case (stateReg)
      COUNT_HI, COUNT_LO, DATA: byteReady = armedReg;
`ifdef LOADER_CHECKSUM_EN
      CHECK:                    byteReady = armedReg;
`endif
      default:                  byteReady = 1'b0;
    endcase
    transfer = byteValid & byteReady;

`ifdef LOADER_CHECKSUM_EN
    xorNext = transfer ? (xorReg ^ byteIn) : xorReg;
`endif

    case (stateReg)
      COUNT_HI: begin
        if (transfer) begin
          countNext = {byteIn, countReg[7:0]};
          stateNext = COUNT_LO;
        end
      end
      COUNT_LO: begin
        if (transfer) begin
          countNext = {countReg[15:8], byteIn};
          if ({1'b0, countNext} > CAPACITY)
            stateNext = ERROR;
          else if (countNext == 16'd0)
            stateNext = AFTER_LAST;
          else
            stateNext = DATA;
        end
      end
      DATA: begin
        if (transfer) begin
          wordNext    = {wordReg[23:0], byteIn};
          byteIdxNext = byteIdxReg + 2'd1;
          if (byteIdxReg == 2'd3)
            stateNext = WRITE;
        end
      end
      WRITE: begin
        memWrite    = 1'b1;
        addrNext    = addrReg + ADDR_WIDTH'(1);
        writtenNext = writtenReg + (ADDR_WIDTH + 1)'(1);
        // The address counter wraps after the last slot; the count check keeps us from writing past it.
        stateNext   = (17'(writtenNext) == {1'b0, countReg}) ? AFTER_LAST : DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (transfer)
          stateNext = ((xorReg ^ byteIn) == 8'd0) ? DONE : ERROR;
      end
`endif
      DONE:    stateNext = DONE;
      ERROR:   stateNext = ERROR;
      default: stateNext = ERROR;
    endcase
  end

  assign memAddress = addrReg;
  assign memData    = wordReg;
  assign cpuHold    = (stateReg != DONE);
  assign done       = (stateReg == DONE);
  assign error      = (stateReg == ERROR);

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboarded bench for instruction_loader: a stream-level model predicts writes and final outcome,
// a negedge monitor checks every memory write against the queue. Honours LOADER_CHECKSUM_EN.
module tb_instruction_loader;
  localparam int AW  = 8;
  localparam int CAP = 1 << AW;

  typedef logic [7:0] byteQ_t[$];
  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  logic          clk       = 1'b0;
  logic          reset     = 1'b0;
  logic [7:0]    byteIn    = 8'h00;
  logic          byteValid = 1'b0;
  logic          byteReady, memWrite, cpuHold, done, error;
  logic [AW-1:0] memAddress;
  logic [31:0]   memData;

  int     checks   = 0;
  int     failures = 0;
  int     cyc      = 0;
  bit     monOn    = 1'b0;
  byteQ_t stim;
  wr_t    expWr[$];
  int     expCyc[$];
  int     expOutcome;   // 0 incomplete, 1 done, 2 error
  int     expWords;
  wr_t    monW;
  int     monC;

  instruction_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .byteIn(byteIn), .byteValid(byteValid), .byteReady(byteReady),
    .memWrite(memWrite), .memAddress(memAddress), .memData(memData),
    .cpuHold(cpuHold), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: derives the write list and final outcome directly from the stream format.
  task automatic model(input int sent);
    int         count;
    logic [7:0] x;
    expOutcome = 0;
    count      = int'({stim[0], stim[1]});
    expWords   = count;
    if (count > CAP) begin
      expWords = 0;
      if (sent >= 2) expOutcome = 2;
      return;
    end
    for (int k = 0; k < count; k++)
      if (2 + 4 * k + 3 < sent)
        expWr.push_back('{k % CAP, {stim[2+4*k], stim[3+4*k], stim[4+4*k], stim[5+4*k]}});
    if (sent < stim.size()) return;
`ifdef LOADER_CHECKSUM_EN
    x = 8'h00;
    foreach (stim[i]) x ^= stim[i];
    expOutcome = (x == 8'h00) ? 1 : 2;
`else
    x = 8'h00;
    expOutcome = (x == 8'h00) ? 1 : 2;
`endif
  endtask

  task automatic build(input int count, input int nWords);
    stim.delete();
    stim.push_back(8'(count >> 8));
    stim.push_back(8'(count));
    for (int k = 0; k < 4 * nWords; k++) stim.push_back(8'($urandom));
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic appendChecksum(input bit corrupt);
    logic [7:0] x;
    x = 8'h00;
    foreach (stim[i]) x ^= stim[i];
    if (corrupt) x ^= 8'($urandom_range(1, 255));
    stim.push_back(x);
  endtask
`endif

  task automatic doReset();
    @(negedge clk);
    byteValid = 1'b0;
    reset     = 1'b1;
    #1;
    check("reset_cpuHold", 32'(cpuHold), 32'd1);
    check("reset_memAddress", 32'(memAddress), 32'd0);
    check("reset_done_error", 32'({done, error}), 32'd0);
    repeat (2) @(negedge clk);
    check("reset_memData", memData, 32'd0);
    check("reset_memWrite_ready", 32'({memWrite, byteReady}), 32'd0);
    expWr.delete();
    expCyc.delete();
    reset = 1'b0;
    monOn = 1'b1;
    #1;
    check("ready_first_cycle", 32'(byteReady), 32'd0);
    @(negedge clk);
    check("ready_armed", 32'(byteReady), 32'd1);
    check("hold_while_loading", 32'(cpuHold), 32'd1);
  endtask

  task automatic send(input int mode, input int sent);
    int i      = 0;
    int budget = 0;
    bit tog    = 1'b0;
    bit v;
    while (i < sent && budget < 6000) begin
      @(negedge clk);
      budget++;
      case (mode)
        0:       v = 1'b1;
        1:       begin tog = ~tog; v = tog; end
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      byteIn    = stim[i];
      byteValid = v;
      check("ready_outside_write", 32'(byteReady | memWrite), 32'd1);
      if (v && byteReady) begin
        if (i >= 2 && i < 2 + 4 * expWords && ((i - 2) % 4) == 3) expCyc.push_back(cyc + 1);
        i++;
      end
    end
    if (i < sent) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got %0d bytes accepted, required %0d", i, sent);
    end
    @(negedge clk);
    byteValid = 1'b0;
  endtask

  task automatic finalChecks(input string tag);
    for (int k = 0; k < 40 && !(done || error); k++) @(negedge clk);
    check("final_done", 32'(done), 32'(expOutcome == 1));
    check("final_error", 32'(error), 32'(expOutcome == 2));
    check("final_cpuHold", 32'(cpuHold), 32'(expOutcome != 1));
    check("final_addr", 32'(memAddress), 32'(expWords % CAP));
    check("pending_writes", 32'(expWr.size()), 32'd0);
    repeat (3) begin
      @(negedge clk);
      byteIn    = 8'($urandom);
      byteValid = 1'b1;
      #1;
      check("extra_byte_refused", 32'(byteReady), 32'd0);
    end
    @(negedge clk);
    byteValid = 1'b0;
    check("outcome_sticky", 32'({done, error}), 32'({expOutcome == 1, expOutcome == 2}));
    $display("test %s: bytes=%0d done=%0b error=%0b", tag, stim.size(), done, error);
  endtask

  task automatic runStream(input int mode, input string tag);
    doReset();
    model(stim.size());
    send(mode, stim.size());
    finalChecks(tag);
  endtask

  always @(negedge clk) begin
    if (monOn && !reset) begin
      check("done_error_exclusive", 32'(done & error), 32'd0);
      if (memWrite) begin
        if (expWr.size() == 0 || expCyc.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr=%0d data=0x%08h, required no write", memAddress, memData);
        end else begin
          monW = expWr.pop_front();
          monC = expCyc.pop_front();
          check("write_addr", 32'(memAddress), 32'(monW.addr));
          check("write_data", memData, monW.data);
          check("write_cycle", 32'(cyc), 32'(monC));
          check("write_ready_low", 32'(byteReady), 32'd0);
          $display("write addr=%0d data=0x%08h cycle=%0d", memAddress, memData, cyc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit corrupt;
    int cnt;
    corrupt = 1'b0;

    stim = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
`ifdef LOADER_CHECKSUM_EN
    appendChecksum(1'b0);
`endif
    runStream(0, "two_words_streaming");
    runStream(1, "two_words_toggled");

    stim = {8'h01, 8'h01};
    runStream(0, "count_over_capacity");

`ifdef LOADER_CHECKSUM_EN
    stim = {8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    runStream(0, "bad_checksum");
`endif

    // Partial load interrupted by reset, then the whole image again.
    stim = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
`ifdef LOADER_CHECKSUM_EN
    appendChecksum(1'b0);
`endif
    doReset();
    model(6);
    send(0, 6);
    repeat (3) @(negedge clk);
    check("midload_pending", 32'(expWr.size()), 32'd0);
    check("midload_addr", 32'(memAddress), 32'd1);
    check("midload_hold", 32'(cpuHold), 32'd1);
    runStream(2, "reload_after_reset");

    build(0, 0);
`ifdef LOADER_CHECKSUM_EN
    appendChecksum(1'b0);
`endif
    runStream(0, "empty_image");

    build(CAP, CAP);
`ifdef LOADER_CHECKSUM_EN
    appendChecksum(1'b0);
`endif
    runStream(2, "full_capacity");

    build(CAP + 1, 0);
    runStream(0, "capacity_plus_one");
    build(16'hFFFF, 0);
    runStream(2, "count_ffff");

    for (int t = 0; t < 8; t++) begin
      cnt = int'($urandom_range(1, 6));
      build(cnt, cnt);
`ifdef LOADER_CHECKSUM_EN
      corrupt = ($urandom_range(0, 3) == 0);
      appendChecksum(corrupt);
`endif
      runStream(int'($urandom_range(0, 2)), corrupt ? "random_corrupt" : "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
